// File: rtl/joy_db9md_multi.sv
// joy_db9md_multi
// Mega Drive / Master System DB9 pad reader. NUM_PORTS pads share one 6-bit
// bus through an external splitter. Once per frame the reader runs the
// 8-step select sequence, time-slicing every step across the splitter ports.
// Each port keeps a shadow word. All shadows publish together at the end of
// step 7.
//
// Optional build macro JOY_DB9MD_DEBOUNCE_EN: a port publishes only when its
// new capture equals the capture from the previous frame.

module joy_db9md_multi #(
    parameter int NUM_PORTS   = 2,
    parameter int SLOT_CLKS   = 64,
    parameter int FRAME_STEPS = 1024,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                joy_in,
    output logic                      joy_mdsel,
    output logic [PW-1:0]             joy_split,
    output logic [12*NUM_PORTS-1:0]   joystick,
    output logic [NUM_PORTS-1:0]      pad_md,
    output logic [NUM_PORTS-1:0]      pad_6btn,
    output logic                      frame_done
);

    localparam int SW  = $clog2(SLOT_CLKS);
    localparam int STW = $clog2(FRAME_STEPS);

    localparam logic [SW-1:0]  SLOT_LAST = SW'(SLOT_CLKS - 1);
    localparam logic [PW-1:0]  PORT_LAST = PW'(NUM_PORTS - 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(FRAME_STEPS - 1);

    // Select sequence steps that carry a sample
    localparam logic [STW-1:0] STEP_DIR  = STW'(0);  // sel=1: dirs, B, C
    localparam logic [STW-1:0] STEP_MDID = STW'(1);  // sel=0: MD id, Start, A
    localparam logic [STW-1:0] STEP_6ID  = STW'(5);  // sel=0: 6-button id
    localparam logic [STW-1:0] STEP_XYZ  = STW'(6);  // sel=1: Z, Y, X, Mode
    localparam logic [STW-1:0] STEP_PUB  = STW'(7);  // last sequence step
    localparam logic [STW-1:0] STEP_IDLE = STW'(8);  // first idle step

    // ------------------------------------------------------------------
    // Timebase: slot clock counter -> port index -> step counter
    // ------------------------------------------------------------------
    logic [SW-1:0]  slot_cnt_reg;
    logic [SW-1:0]  slot_cnt_next;
    logic [PW-1:0]  port_reg;
    logic [PW-1:0]  port_next;
    logic [STW-1:0] step_reg;
    logic [STW-1:0] step_next;
    logic           mdsel_reg;
    logic           mdsel_next;
    logic           frame_done_reg;

    logic           slot_end;
    logic           step_end;
    logic           publish;

    assign slot_end = (slot_cnt_reg == SLOT_LAST);
    assign step_end = slot_end && (port_reg == PORT_LAST);
    assign publish  = step_end && (step_reg == STEP_PUB);

    // Next counter values and the select level for the step being entered
    always_comb begin
        slot_cnt_next = slot_cnt_reg + SW'(1);
        port_next     = port_reg;
        step_next     = step_reg;
        if (slot_end) begin
            slot_cnt_next = '0;
            if (port_reg == PORT_LAST) begin
                port_next = '0;
            end else begin
                port_next = port_reg + PW'(1);
            end
        end
        if (step_end) begin
            if (step_reg == STEP_LAST) begin
                step_next = '0;
            end else begin
                step_next = step_reg + STW'(1);
            end
        end
        // Even sequence steps and all idle steps keep select high
        if (step_next < STEP_IDLE) begin
            mdsel_next = ~step_next[0];
        end else begin
            mdsel_next = 1'b1;
        end
    end

    // Counter state and registered bus controls (no decode glitches on pins)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_reg   <= '0;
            port_reg       <= '0;
            step_reg       <= '0;
            mdsel_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            slot_cnt_reg   <= slot_cnt_next;
            port_reg       <= port_next;
            step_reg       <= step_next;
            mdsel_reg      <= mdsel_next;
            frame_done_reg <= publish;
        end
    end

    assign joy_mdsel  = mdsel_reg;
    assign joy_split  = port_reg;
    assign frame_done = frame_done_reg;

    // ------------------------------------------------------------------
    // Per-port shadow capture and publish
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [11:0] word_reg;
            logic        md_reg;
            logic        six_reg;
            logic [11:0] pub_word_reg;
            logic        pub_md_reg;
            logic        pub_six_reg;
            logic        capture;

            // Sample only on the settled last clock of this port's slot
            assign capture = slot_end && (port_reg == PW'(gi));

            // Shadow capture; bit layout matches the published word
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                    md_reg   <= 1'b0;
                    six_reg  <= 1'b0;
                end else if (capture) begin
                    if (step_reg == STEP_DIR) begin
                        word_reg[3:0] <= ~joy_in[3:0];
                        word_reg[5]   <= ~joy_in[4];
                        word_reg[6]   <= ~joy_in[5];
                    end else if (step_reg == STEP_MDID) begin
                        // MD pads pull Left/Right low while select is low
                        if (joy_in[1:0] == 2'b00) begin
                            md_reg       <= 1'b1;
                            word_reg[10] <= ~joy_in[5];
                            word_reg[4]  <= ~joy_in[4];
                        end else begin
                            md_reg       <= 1'b0;
                            word_reg[10] <= 1'b0;
                            word_reg[4]  <= 1'b0;
                        end
                    end else if (step_reg == STEP_6ID) begin
                        // Third low pulse: 6-button pads drive all four low
                        six_reg <= md_reg && (joy_in[3:0] == 4'b0000);
                    end else if (step_reg == STEP_XYZ) begin
                        if (six_reg) begin
                            word_reg[9]  <= ~joy_in[3];
                            word_reg[8]  <= ~joy_in[2];
                            word_reg[7]  <= ~joy_in[1];
                            word_reg[11] <= ~joy_in[0];
                        end else begin
                            word_reg[9]  <= 1'b0;
                            word_reg[8]  <= 1'b0;
                            word_reg[7]  <= 1'b0;
                            word_reg[11] <= 1'b0;
                        end
                    end
                end
            end

`ifdef JOY_DB9MD_DEBOUNCE_EN
            logic [13:0] prev_reg;
            logic [13:0] snap;

            assign snap = {six_reg, md_reg, word_reg};

            // Publish only a capture that repeated across two frames
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prev_reg     <= '0;
                    pub_word_reg <= '0;
                    pub_md_reg   <= 1'b0;
                    pub_six_reg  <= 1'b0;
                end else if (publish) begin
                    prev_reg <= snap;
                    if (snap == prev_reg) begin
                        pub_word_reg <= word_reg;
                        pub_md_reg   <= md_reg;
                        pub_six_reg  <= six_reg;
                    end
                end
            end
`else
            // Publish every frame's capture
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pub_word_reg <= '0;
                    pub_md_reg   <= 1'b0;
                    pub_six_reg  <= 1'b0;
                end else if (publish) begin
                    pub_word_reg <= word_reg;
                    pub_md_reg   <= md_reg;
                    pub_six_reg  <= six_reg;
                end
            end
`endif

            assign joystick[12*gi +: 12] = pub_word_reg;
            assign pad_md[gi]            = pub_md_reg;
            assign pad_6btn[gi]          = pub_six_reg;
        end
    endgenerate

endmodule
